// File: rtl/amm_master_ctrl.sv
// rtl/amm_master_ctrl.sv - Avalon-MM initiator: single-beat commands to pipelined read/write transfers.
// Optional watchdog abort is enabled by defining AMM_TIMEOUT_EN.
module amm_master_ctrl #(
  parameter int ADDR_WIDTH     = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_PENDING    = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_address,
  input  logic [DATA_WIDTH-1:0] cmd_writedata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_readdata,
  output logic                  rsp_error,
  output logic                  err_spurious,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [DATA_WIDTH-1:0] avm_writedata,
  input  logic [DATA_WIDTH-1:0] avm_readdata,
  input  logic                  avm_readdatavalid,
  input  logic                  avm_waitrequest
);

  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam logic [PW-1:0] PMAX = PW'(MAX_PENDING);

  if (MAX_PENDING < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("amm_master_ctrl: MAX_PENDING and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [PW-1:0]         r_pending;
  logic                  r_read;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_err_spurious;

  logic w_cmd_fire;
  logic w_xfer_acc;
  logic w_rd_acc;
  logic w_rdv_ok;
  logic w_rdv_bad;
  logic w_timeout;

  // Gating with reset keeps cmd_ready at 0 for the whole reset window.
  assign cmd_ready  = ~reset & (r_state == S_IDLE) & (r_pending < PMAX);
  assign w_cmd_fire = cmd_valid & cmd_ready;
  assign w_xfer_acc = (r_state == S_ISSUE) & ~avm_waitrequest;
  assign w_rd_acc   = w_xfer_acc & r_read;
  assign w_rdv_ok   = avm_readdatavalid & (r_pending != '0);
  assign w_rdv_bad  = avm_readdatavalid & (r_pending == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_fire) w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_xfer_acc || w_timeout) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_timeout) begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
    end else if (w_cmd_fire) begin
      r_addr  <= cmd_address;
      r_wdata <= cmd_writedata;
      r_read  <= ~cmd_write;
      r_write <= cmd_write;
    end else if (w_xfer_acc) begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
    end
  end

  // Accept and return in the same cycle cancel out; saturation guard keeps the counter from wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
    end else if (w_timeout) begin
      r_pending <= '0;
    end else begin
      case ({w_rd_acc && (r_pending != PMAX), w_rdv_ok})
        2'b10:   r_pending <= r_pending + PW'(1);
        2'b01:   r_pending <= r_pending - PW'(1);
        default: r_pending <= r_pending;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid    <= 1'b0;
      r_rsp_data     <= '0;
      r_err_spurious <= 1'b0;
    end else begin
      r_rsp_valid    <= w_rdv_ok;
      r_err_spurious <= r_err_spurious | w_rdv_bad;
      if (w_rdv_ok) r_rsp_data <= avm_readdata;
    end
  end

`ifdef AMM_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] r_wd;
  logic          r_rsp_error;
  logic          w_wd_run;
  logic          w_wd_clear;

  assign w_wd_run   = (r_state == S_ISSUE) | (r_pending != '0);
  assign w_wd_clear = w_xfer_acc | avm_readdatavalid;
  assign w_timeout  = w_wd_run & ~w_wd_clear & (r_wd == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd        <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      r_rsp_error <= w_timeout;
      if (w_wd_clear || w_timeout || !w_wd_run) r_wd <= '0;
      else r_wd <= r_wd + WW'(1);
    end
  end

  assign rsp_error = r_rsp_error;
`else
  assign w_timeout = 1'b0;
  assign rsp_error = 1'b0;
`endif

  assign busy          = (r_state != S_IDLE) | (r_pending != '0);
  assign avm_address   = r_addr;
  assign avm_read      = r_read;
  assign avm_write     = r_write;
  assign avm_writedata = r_wdata;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_readdata  = r_rsp_data;
  assign err_spurious  = r_err_spurious;

endmodule
